matrix_scan_reader: RTL

//  Read-side consumer of the 24x16 game frame matrix. Fetches one column of 16 pixels at a time

---
 rtl/matrix_scan_reader.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/matrix_scan_reader.sv
// matrix_scan_reader
//   Read-side consumer of the game frame matrix. One column of pixels is fetched
//   at a time from the frame store, which has a 1-cycle read latency. The column
//   is lit for DWELL_CYCLES, and then the display is blanked for BLANK_CYCLES.
//   After that the scan moves on to the next column. It runs continuously,
//   wraps from the last column back to 0, and pulses frame_done on the first
//   fetch of each new frame.
//
// Ports
//   clk1000    system clock
//   rst_n      synchronous reset, active low
//   en         scan enable; low drops to IDLE with the display dark
//   rd_en      one-cycle read strobe to the frame store
//   rd_col     column address qualified by rd_en
//   rd_data    column pixels (bit j = row j), valid the cycle after rd_en
//   col_en     one-hot column drive, all zero when dark
//   row_out    row drive for the lit column (inverted when ROW_ACTIVE_LOW)
//   scan_col   column currently being processed
//   frame_done one-cycle pulse on the fetch that follows a completed frame
module matrix_scan_reader #(
    parameter int NUM_COLS       = 24,
    parameter int NUM_ROWS       = 16,
    parameter int DWELL_CYCLES   = 4,
    parameter int BLANK_CYCLES   = 1,
    parameter int ROW_ACTIVE_LOW = 0
) (
    input  logic                clk1000,
    input  logic                rst_n,
    input  logic                en,
    output logic                rd_en,
    output logic [4:0]          rd_col,
    input  logic [NUM_ROWS-1:0] rd_data,
    output logic [NUM_COLS-1:0] col_en,
    output logic [NUM_ROWS-1:0] row_out,
    output logic [4:0]          scan_col,
    output logic                frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        SHOW,
        BLANK
    } state_e;

    // A single counter serves both the dwell phase and the blank phase, so it is sized for the longer one.
    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]    DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0]    BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
    localparam logic [4:0]          LAST_COL   = 5'(NUM_COLS - 1);
    localparam logic [NUM_COLS-1:0] COL_ONE    = NUM_COLS'(1);
    localparam logic [NUM_ROWS-1:0] ROW_IDLE   = {NUM_ROWS{ROW_ACTIVE_LOW != 0}};

    state_e              state_q,      state_d;
    logic [4:0]          scan_col_q,   scan_col_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
    logic [NUM_ROWS-1:0] latch_q,      latch_d;
    logic                rd_en_q,      rd_en_d;
    logic [4:0]          rd_col_q,     rd_col_d;
    logic [NUM_COLS-1:0] col_en_q,     col_en_d;
    logic [NUM_ROWS-1:0] row_out_q,    row_out_d;
    logic                frame_done_q, frame_done_d;
    logic                advance;
    logic                frame_wrap;

    // State register. All outputs are flops as well. Reset takes priority over en.
    always_ff @(posedge clk1000) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            scan_col_q   <= '0;
            cnt_q        <= '0;
            latch_q      <= '0;
            rd_en_q      <= 1'b0;
            rd_col_q     <= '0;
            col_en_q     <= '0;
            row_out_q    <= ROW_IDLE;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            scan_col_q   <= scan_col_d;
            cnt_q        <= cnt_d;
            latch_q      <= latch_d;
            rd_en_q      <= rd_en_d;
            rd_col_q     <= rd_col_d;
            col_en_q     <= col_en_d;
            row_out_q    <= row_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state logic.
    // The column latch captures rd_data only on the last edge of WAIT. This means
    // a frame-store write can never tear a column that is already on display.
    // Dropping en abandons the scan, and the next enable always restarts at column 0.
    always_comb begin
        state_d    = state_q;
        scan_col_d = scan_col_q;
        cnt_d      = cnt_q;
        latch_d    = latch_q;
        advance    = 1'b0;
        frame_wrap = 1'b0;

        if (state_q == WAIT) begin
            latch_d = rd_data;
        end

        if (!en) begin
            state_d    = IDLE;
            scan_col_d = '0;
            cnt_d      = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = FETCH;
                    scan_col_d = '0;
                end
                FETCH: begin
                    state_d = WAIT;
                end
                WAIT: begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end
                SHOW: begin
                    if (cnt_q == DWELL_LAST) begin
                        cnt_d = '0;
                        if (BLANK_CYCLES > 0) begin
                            state_d = BLANK;
                        end else begin
                            state_d = FETCH;
                            advance = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        cnt_d   = '0;
                        state_d = FETCH;
                        advance = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    scan_col_d = '0;
                    cnt_d      = '0;
                end
            endcase

            if (advance) begin
                if (scan_col_q == LAST_COL) begin
                    scan_col_d = '0;
                    frame_wrap = 1'b1;
                end else begin
                    scan_col_d = scan_col_q + 5'd1;
                end
            end
        end
    end

    // Output logic.
    // The outputs are decoded from the next state so that, once registered,
    // they line up with the state they describe. On entry to SHOW, latch_d
    // already carries the freshly sampled rd_data.
    always_comb begin
        rd_en_d      = (state_d == FETCH);
        rd_col_d     = (state_d == FETCH) ? scan_col_d : 5'd0;
        frame_done_d = frame_wrap;
        col_en_d     = '0;
        row_out_d    = ROW_IDLE;
        if (state_d == SHOW) begin
            col_en_d  = COL_ONE << scan_col_d;
            row_out_d = (ROW_ACTIVE_LOW != 0) ? ~latch_d : latch_d;
        end
    end

    assign rd_en      = rd_en_q;
    assign rd_col     = rd_col_q;
    assign col_en     = col_en_q;
    assign row_out    = row_out_q;
    assign scan_col   = scan_col_q;
    assign frame_done = frame_done_q;

endmodule
